// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit LC-3b subset core.
package cpu_pkg;

  localparam int LINE_W = 128;
  localparam int WORD_W = 16;

  typedef enum logic [3:0] {
    OP_BR  = 4'h0,
    OP_ADD = 4'h1,
    OP_AND = 4'h5,
    OP_LDR = 4'h6,
    OP_STR = 4'h7,
    OP_NOT = 4'h9,
    OP_JMP = 4'hC,
    OP_LEA = 4'hE
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXECUTE,
    S_LD_RD,
    S_ST_RD,
    S_ST_WR
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_AND,
    ALU_NOT,
    ALU_PASS
  } alu_op_e;

  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [2:0]        idx);
    return line[idx*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/cpu_if.sv
// Line-memory port between the core (master) and the memory (slave).
interface cpu_if;
  import cpu_pkg::*;

  logic              pmem_resp;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_read;
  logic              pmem_write;
  logic [15:0]       pmem_address;
  logic [LINE_W-1:0] pmem_wdata;

  modport master (
    input  pmem_resp, pmem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport slave (
    output pmem_resp, pmem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/cpu_alu.sv
// 16-bit ALU (ADD/AND/NOT/pass) with nzp condition-code generation.
module cpu_alu
  import cpu_pkg::*;
(
  input  alu_op_e           i_op,
  input  logic [WORD_W-1:0] i_a,
  input  logic [WORD_W-1:0] i_b,
  output logic [WORD_W-1:0] o_result,
  output logic [2:0]        o_cc
);

  always_comb begin
    o_result = i_a;
    case (i_op)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_AND:  o_result = i_a & i_b;
      ALU_NOT:  o_result = ~i_a;
      ALU_PASS: o_result = i_a;
      default:  o_result = i_a;
    endcase
  end

  assign o_cc = o_result[WORD_W-1]  ? 3'b100 :
                (o_result == '0)    ? 3'b010 : 3'b001;

endmodule

// File: rtl/cpu_core.sv
// Multicycle 16-bit LC-3b subset core: fetch/execute control, register file,
// and line read-modify-write for stores.
//
// state     | meaning
// S_FETCH   | read instruction line at PC, latch IR, PC += 2
// S_EXECUTE | decode IR, ALU/branch/jump, or latch EA for LDR/STR
// S_LD_RD   | read line at EA, write word to DR and set CC
// S_ST_RD   | read line at EA, merge source register into line buffer
// S_ST_WR   | write line buffer back to EA line
module cpu_core
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic   clk,
  input logic   rst_n,
  cpu_if.master pmem
);

  state_e            r_state;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_ir;
  logic [2:0]        r_cc;
  logic [WORD_W-1:0] r_regs [8];
  logic [LINE_W-1:0] r_buf;
  logic [15:1]       r_ea;

  state_e            w_next_state;
  opcode_e           w_opcode;
  logic [2:0]        w_dr;
  logic [WORD_W-1:0] w_sr1_val;
  logic [WORD_W-1:0] w_sr2_val;
  logic [WORD_W-1:0] w_dr_val;
  logic [WORD_W-1:0] w_imm5;
  logic [WORD_W-1:0] w_pc_off9;
  logic [15:1]       w_ea;
  logic [WORD_W-1:0] w_rd_word;
  logic [LINE_W-1:0] w_merged;
  logic              w_read;
  logic              w_write;
  logic [15:4]       w_addr_line;
  logic              w_ir_we;
  logic              w_pc_we;
  logic [WORD_W-1:0] w_pc_nxt;
  logic              w_reg_we;
  logic              w_cc_we;
  logic              w_ea_we;
  logic              w_buf_we;
  alu_op_e           w_alu_op;
  logic [WORD_W-1:0] w_alu_a;
  logic [WORD_W-1:0] w_alu_b;
  logic [WORD_W-1:0] w_alu_res;
  logic [2:0]        w_alu_cc;

  assign w_opcode  = opcode_e'(r_ir[15:12]);
  assign w_dr      = r_ir[11:9];
  assign w_sr1_val = r_regs[r_ir[8:6]];
  assign w_sr2_val = r_regs[r_ir[2:0]];
  assign w_dr_val  = r_regs[w_dr];
  assign w_imm5    = {{11{r_ir[4]}}, r_ir[4:0]};
  assign w_pc_off9 = r_pc + {{6{r_ir[8]}}, r_ir[8:0], 1'b0};
  // offset is pre-shifted, so only bits [15:1] of the EA are ever needed
  assign w_ea      = w_sr1_val[15:1] + {{9{r_ir[5]}}, r_ir[5:0]};
  assign w_rd_word = line_word(pmem.pmem_rdata, (r_state == S_FETCH) ? r_pc[3:1] : r_ea[3:1]);

  always_comb begin
    w_merged = pmem.pmem_rdata;
    w_merged[r_ea[3:1]*WORD_W +: WORD_W] = w_dr_val;
  end

  cpu_alu u_alu (
    .i_op     (w_alu_op),
    .i_a      (w_alu_a),
    .i_b      (w_alu_b),
    .o_result (w_alu_res),
    .o_cc     (w_alu_cc)
  );

  always_comb begin
    w_next_state = r_state;
    w_read       = 1'b0;
    w_write      = 1'b0;
    w_addr_line  = r_pc[15:4];
    w_ir_we      = 1'b0;
    w_pc_we      = 1'b0;
    w_pc_nxt     = r_pc;
    w_reg_we     = 1'b0;
    w_cc_we      = 1'b0;
    w_ea_we      = 1'b0;
    w_buf_we     = 1'b0;
    w_alu_op     = ALU_PASS;
    w_alu_a      = w_rd_word;
    w_alu_b      = w_sr2_val;
    case (r_state)
      S_FETCH: begin
        w_read = 1'b1;
        if (pmem.pmem_resp) begin
          w_ir_we      = 1'b1;
          w_pc_we      = 1'b1;
          w_pc_nxt     = r_pc + 16'd2;
          w_next_state = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        w_next_state = S_FETCH;
        case (w_opcode)
          OP_ADD, OP_AND: begin
            w_alu_op = (w_opcode == OP_ADD) ? ALU_ADD : ALU_AND;
            w_alu_a  = w_sr1_val;
            w_alu_b  = r_ir[5] ? w_imm5 : w_sr2_val;
            w_reg_we = 1'b1;
            w_cc_we  = 1'b1;
          end
          OP_NOT: begin
            w_alu_op = ALU_NOT;
            w_alu_a  = w_sr1_val;
            w_reg_we = 1'b1;
            w_cc_we  = 1'b1;
          end
          OP_LEA: begin
            w_alu_a  = w_pc_off9;
            w_reg_we = 1'b1;
            w_cc_we  = 1'b1;
          end
          OP_BR: begin
            if ((r_ir[11:9] & r_cc) != 3'b000) begin
              w_pc_we  = 1'b1;
              w_pc_nxt = w_pc_off9;
            end
          end
          OP_JMP: begin
            w_pc_we  = 1'b1;
            w_pc_nxt = w_sr1_val;
          end
          OP_LDR: begin
            w_ea_we      = 1'b1;
            w_next_state = S_LD_RD;
          end
          OP_STR: begin
            w_ea_we      = 1'b1;
            w_next_state = S_ST_RD;
          end
          default: ;
        endcase
      end
      S_LD_RD: begin
        w_read      = 1'b1;
        w_addr_line = r_ea[15:4];
        if (pmem.pmem_resp) begin
          w_reg_we     = 1'b1;
          w_cc_we      = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      S_ST_RD: begin
        w_read      = 1'b1;
        w_addr_line = r_ea[15:4];
        if (pmem.pmem_resp) begin
          w_buf_we     = 1'b1;
          w_next_state = S_ST_WR;
        end
      end
      S_ST_WR: begin
        w_write     = 1'b1;
        w_addr_line = r_ea[15:4];
        if (pmem.pmem_resp) w_next_state = S_FETCH;
      end
      default: w_next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_cc    <= 3'b010;
      r_buf   <= '0;
      r_ea    <= '0;
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_ir_we)  r_ir         <= w_rd_word;
      if (w_pc_we)  r_pc         <= w_pc_nxt;
      if (w_reg_we) r_regs[w_dr] <= w_alu_res;
      if (w_cc_we)  r_cc         <= w_alu_cc;
      if (w_ea_we)  r_ea         <= w_ea;
      if (w_buf_we) r_buf        <= w_merged;
    end
  end

  // requests are gated by reset so the port goes quiet the instant rst_n falls
  assign pmem.pmem_read    = rst_n & w_read;
  assign pmem.pmem_write   = rst_n & w_write;
  assign pmem.pmem_address = rst_n ? {w_addr_line, 4'h0} : 16'h0000;
  assign pmem.pmem_wdata   = r_buf;

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: directed programs plus random programs
// compared transaction-by-transaction against an instruction-level model.
module tb_cpu_core;
  import cpu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_if u_if();
  cpu_core #(.RESET_PC(16'h0000)) u_dut (.clk(clk), .rst_n(rst_n), .pmem(u_if));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // magic memory: 4096 lines of 16 bytes, resp one cycle after request
  logic [LINE_W-1:0] mem [4096];
  logic              r_resp;
  int                cyc = 0;

  assign u_if.pmem_resp  = r_resp;
  assign u_if.pmem_rdata = mem[u_if.pmem_address[15:4]];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_resp <= 1'b0;
    else begin
      r_resp <= (u_if.pmem_read || u_if.pmem_write) && !r_resp;
      if (r_resp && u_if.pmem_write) mem[u_if.pmem_address[15:4]] = u_if.pmem_wdata;
    end
  end

  // reference model state: word-addressed memory and architectural registers
  logic [15:0] mmem [32768];
  logic [15:0] m_r [8];
  logic [2:0]  m_cc;

  typedef struct {
    bit           wr;
    logic [15:0]  addr;
    logic [127:0] data;
    int           cyc;
  } txn_t;

  txn_t exp_q[$];
  txn_t obs_q[$];
  int   exp_cycles;
  bit   mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("rw_excl", u_if.pmem_read & u_if.pmem_write, 1'b0);
      if (u_if.pmem_read | u_if.pmem_write) check_eq("addr_align", u_if.pmem_address[3:0], 4'h0);
      if (u_if.pmem_resp)
        obs_q.push_back('{u_if.pmem_write, u_if.pmem_address, u_if.pmem_wdata, cyc});
    end
  end

  task automatic clear_mem();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    for (int i = 0; i < 32768; i++) mmem[i] = '0;
  endtask

  task automatic put_word(input logic [15:0] a, input logic [15:0] w);
    mem[a[15:4]][a[3:1]*16 +: 16] = w;
    mmem[a[15:1]] = w;
  endtask

  function automatic logic [127:0] m_line(input logic [15:0] a);
    logic [127:0] l;
    for (int k = 0; k < 8; k++) l[k*16 +: 16] = mmem[{a[15:4], 3'(k)}];
    return l;
  endfunction

  function automatic logic [2:0] nzp(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'd0)     return 3'b010;
    return 3'b001;
  endfunction

  task automatic push_exp(input bit wr, input logic [15:0] a, input logic [127:0] d);
    exp_q.push_back('{wr, {a[15:4], 4'h0}, d, 0});
  endtask

  task automatic model_run(input logic [15:0] halt_pc, input int max_steps);
    logic [15:0] pc, ir, a, b, off9, ea;
    logic [2:0]  dr;
    pc = 16'h0000;
    m_cc = 3'b010;
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    exp_q.delete();
    exp_cycles = 0;
    for (int s = 0; s < max_steps && pc != halt_pc; s++) begin
      ir = mmem[pc[15:1]];
      push_exp(1'b0, pc, m_line(pc));
      pc = pc + 16'd2;
      exp_cycles += 3;
      dr   = ir[11:9];
      a    = m_r[ir[8:6]];
      b    = ir[5] ? {{11{ir[4]}}, ir[4:0]} : m_r[ir[2:0]];
      off9 = {{6{ir[8]}}, ir[8:0], 1'b0};
      ea   = a + {{9{ir[5]}}, ir[5:0], 1'b0};
      case (ir[15:12])
        4'h1: begin m_r[dr] = a + b;     m_cc = nzp(m_r[dr]); end
        4'h5: begin m_r[dr] = a & b;     m_cc = nzp(m_r[dr]); end
        4'h9: begin m_r[dr] = ~a;        m_cc = nzp(m_r[dr]); end
        4'hE: begin m_r[dr] = pc + off9; m_cc = nzp(m_r[dr]); end
        4'h0: if ((ir[11:9] & m_cc) != 3'b000) pc = pc + off9;
        4'hC: pc = a;
        4'h6: begin
          push_exp(1'b0, ea, m_line(ea));
          m_r[dr] = mmem[ea[15:1]];
          m_cc = nzp(m_r[dr]);
          exp_cycles += 2;
        end
        4'h7: begin
          push_exp(1'b0, ea, m_line(ea));
          mmem[ea[15:1]] = m_r[dr];
          push_exp(1'b1, ea, m_line(ea));
          exp_cycles += 4;
        end
        default: ;
      endcase
    end
    push_exp(1'b0, pc, m_line(pc));
  endtask

  task automatic run_traced(input int budget);
    obs_q.delete();
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int c = 0; c < budget && obs_q.size() < exp_q.size(); c++) @(posedge clk);
    mon_en = 1'b0;
    check_eq("txn_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check_eq("txn_kind_addr", {obs_q[i].wr, obs_q[i].addr}, {exp_q[i].wr, exp_q[i].addr});
      if (exp_q[i].wr) check_eq("txn_wdata", obs_q[i].data, exp_q[i].data);
    end
    if (obs_q.size() == exp_q.size() && obs_q.size() > 0)
      check_eq("latency", obs_q[obs_q.size()-1].cyc - obs_q[0].cyc, exp_cycles);
  endtask

  task automatic load_prog_a();
    logic [15:0] prog [11] = '{16'h1225, 16'h147A, 16'h0801, 16'h1A21, 16'hE60B, 16'h72C1,
                               16'h68C1, 16'h74C2, 16'h78C3, 16'h7AC4, 16'h0FFF};
    clear_mem();
    for (int i = 0; i < 11; i++) put_word(16'(2*i), prog[i]);
    for (int k = 0; k < 8; k++) put_word(16'h0020 + 16'(2*k), 16'hA000 + 16'(k));
  endtask

  task automatic load_prog_b(input logic [15:0] br_word);
    clear_mem();
    put_word(16'h0000, 16'h5020);
    put_word(16'h0002, 16'h0E06);
    put_word(16'h0010, br_word);
    put_word(16'h0012, 16'h701F);
    put_word(16'h0014, 16'h0FFF);
    put_word(16'h003E, 16'hBEEF);
  endtask

  task automatic gen_random(input int n);
    logic [3:0]  nops [8] = '{4'h2, 4'h3, 4'h4, 4'h8, 4'hA, 4'hB, 4'hD, 4'hF};
    logic [15:0] w;
    logic [2:0]  dr, sr1;
    int          i, k, lim;
    clear_mem();
    put_word(16'h0000, 16'hECFF);
    i = 1;
    while (i < n) begin
      k   = $urandom_range(0, 9);
      dr  = 3'($urandom_range(0, 5));
      sr1 = 3'($urandom_range(0, 7));
      case (k)
        0, 1, 2: begin
          if ($urandom_range(0, 1) == 1) w = {(k == 2) ? 4'h5 : 4'h1, dr, sr1, 1'b1, 5'($urandom)};
          else w = {(k == 2) ? 4'h5 : 4'h1, dr, sr1, 3'b000, 3'($urandom)};
        end
        3: w = {4'h9, dr, sr1, 6'h3F};
        4: w = {4'hE, dr, 9'($urandom)};
        5: begin
          lim = (n - i - 1 < 3) ? n - i - 1 : 3;
          w = {4'h0, 3'($urandom), 9'($urandom_range(0, lim))};
        end
        6: w = {4'h6, dr, 3'd6, 6'($urandom)};
        7: w = {4'h7, sr1, 3'd6, 6'($urandom)};
        9: begin
          if (i + 3 <= n) begin
            put_word(16'(2*i), {4'hE, 3'd7, 9'd2});
            i++;
            w = {4'hC, 3'b000, 3'd7, 6'b0};
          end else w = {4'h2, 12'($urandom)};
        end
        default: w = {nops[$urandom_range(0, 7)], 12'($urandom)};
      endcase
      put_word(16'(2*i), w);
      i++;
    end
    put_word(16'(2*n), 16'h0FFF);
    for (int a = 16'h01C0; a < 16'h0240; a += 2) put_word(16'(a), 16'($urandom));
  endtask

  initial begin
    int nwr;

    // reset values, first request, and reset during a write
    load_prog_a();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_read", u_if.pmem_read, 1'b0);
    check_eq("rst_write", u_if.pmem_write, 1'b0);
    check_eq("rst_addr", u_if.pmem_address, 16'h0000);
    check_eq("rst_wdata", u_if.pmem_wdata, 128'd0);
    rst_n = 1'b1;
    #1;
    check_eq("first_read", u_if.pmem_read, 1'b1);
    check_eq("first_addr", u_if.pmem_address, 16'h0000);
    for (int c = 0; c < 200 && !u_if.pmem_write; c++) @(negedge clk);
    check_eq("saw_write", u_if.pmem_write, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_write", u_if.pmem_write, 1'b0);
    check_eq("rst_mid_read", u_if.pmem_read, 1'b0);
    check_eq("rst_mid_addr", u_if.pmem_address, 16'h0000);
    check_eq("rst_mid_wdata", u_if.pmem_wdata, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("refetch_read", u_if.pmem_read, 1'b1);
    check_eq("refetch_addr", u_if.pmem_address, 16'h0000);

    // ADD/BRn/LEA/STR/LDR program with explicit line contents
    load_prog_a();
    model_run(16'h0014, 200);
    run_traced(500);
    check_eq("prog_a_w0", mem[2][15:0], 16'hA000);
    check_eq("prog_a_w1", mem[2][31:16], 16'h0005);
    check_eq("prog_a_w2", mem[2][47:32], 16'hFFFF);
    check_eq("prog_a_w3", mem[2][63:48], 16'h0005);
    check_eq("prog_a_w4", mem[2][79:64], 16'h0000);
    for (int k = 5; k < 8; k++) check_eq("prog_a_wrest", mem[2][k*16 +: 16], 16'hA000 + 16'(k));

    // BRz loop holds at 0x0010 and never reaches the store
    load_prog_b(16'h05FF);
    model_run(16'h0014, 10);
    run_traced(200);
    nwr = 0;
    foreach (obs_q[i]) if (obs_q[i].wr) nwr++;
    check_eq("brz_no_write", nwr, 0);
    check_eq("brz_mem_kept", mem[3][127:112], 16'hBEEF);

    // BRn not taken falls through to the store at 0x0012
    load_prog_b(16'h09FF);
    model_run(16'h0014, 50);
    run_traced(200);
    nwr = 0;
    foreach (obs_q[i]) if (obs_q[i].wr) nwr++;
    check_eq("brn_one_write", nwr, 1);
    check_eq("brn_mem_stored", mem[3][127:112], 16'h0000);

    // random programs
    for (int p = 0; p < 8; p++) begin
      gen_random(40);
      model_run(16'(80), 400);
      run_traced(3000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, limit 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
